// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/lap/clear controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int unsigned SW_MAX_COUNT = 5999;
  localparam logic [3:0]  LAP_NUM_MAX  = 4'd15;

endpackage

// File: rtl/stopwatch_run_ctrl_if.sv
// Button, count and control signals between the board/core side and the run controller.
interface stopwatch_run_ctrl_if #(
  parameter int unsigned COUNT_W = 14
);
  logic               btn_run;
  logic               btn_lap;
  logic               btn_clear;
  logic [COUNT_W-1:0] sw_count;
  logic               run_stop;
  logic               clear;
  logic [COUNT_W-1:0] disp_count;
  logic               lap_active;
  logic [3:0]         lap_num;
  logic [1:0]         state;

  modport master (
    output btn_run, btn_lap, btn_clear, sw_count,
    input  run_stop, clear, disp_count, lap_active, lap_num, state
  );

  modport slave (
    input  btn_run, btn_lap, btn_clear, sw_count,
    output run_stop, clear, disp_count, lap_active, lap_num, state
  );
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> optional debounce -> one-cycle rising-edge pulse.
// Debounce counter is built only when STOPWATCH_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic sync1, sync2;
  logic lvl, lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Count consecutive clocks where the synchronized level disagrees; any agreement restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (sync2 == lvl) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      lvl <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign lvl = sync2;
  if (DEBOUNCE_CYCLES == 0) begin : g_no_counter
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lvl_d <= 1'b0;
    else       lvl_d <= lvl;
  end

  assign pulse = lvl & ~lvl_d;
endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/lap/clear FSM for the stopwatch core, with lap-freeze display path.
// Debounce is enabled by defining STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_run_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned COUNT_W         = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_run_ctrl_if.slave  bus
);
  logic p_run, p_lap, p_clr;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .reset(reset), .btn(bus.btn_run), .pulse(p_run)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(clk), .reset(reset), .btn(bus.btn_lap), .pulse(p_lap)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .reset(reset), .btn(bus.btn_clear), .pulse(p_clr)
  );

  sw_state_e          state_q, state_n;
  logic               run_stop_q, lap_active_q, clear_q, clear_n;
  logic [COUNT_W-1:0] lap_value_q;
  logic [3:0]         lap_num_q;
  logic               capture, zero_laps;

  // Priority clear > run > lap, evaluated only among pulses legal in each state.
  always_comb begin
    state_n   = state_q;
    clear_n   = 1'b0;
    capture   = 1'b0;
    zero_laps = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p_clr) begin
          clear_n   = 1'b1;
          zero_laps = 1'b1;
        end else if (p_run) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (p_run) begin
          state_n = ST_PAUSE;
        end else if (p_lap) begin
          state_n = ST_LAP;
          capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (p_run)      state_n = ST_PAUSE;
        else if (p_lap) state_n = ST_RUN;
      end
      ST_PAUSE: begin
        if (p_clr) begin
          state_n   = ST_IDLE;
          clear_n   = 1'b1;
          zero_laps = 1'b1;
        end else if (p_run) begin
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_stop_q   <= 1'b0;
      lap_active_q <= 1'b0;
      clear_q      <= 1'b0;
      lap_value_q  <= '0;
      lap_num_q    <= '0;
    end else begin
      state_q      <= state_n;
      run_stop_q   <= (state_n == ST_RUN) || (state_n == ST_LAP);
      lap_active_q <= (state_n == ST_LAP);
      clear_q      <= clear_n;
      if (zero_laps) begin
        lap_value_q <= '0;
        lap_num_q   <= '0;
      end else if (capture) begin
        lap_value_q <= bus.sw_count;
        if (lap_num_q != LAP_NUM_MAX) lap_num_q <= lap_num_q + 4'd1;
      end
    end
  end

  assign bus.run_stop   = run_stop_q;
  assign bus.clear      = clear_q;
  assign bus.lap_active = lap_active_q;
  assign bus.lap_num    = lap_num_q;
  assign bus.state      = state_q;
  assign bus.disp_count = lap_active_q ? lap_value_q : bus.sw_count;
endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Self-checking bench for stopwatch_run_ctrl (DEBOUNCE_CYCLES=4); latency follows STOPWATCH_CTRL_DEBOUNCE_EN.
module tb_stopwatch_run_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 14;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam logic [2:0] B_RUN = 3'b001;
  localparam logic [2:0] B_LAP = 3'b010;
  localparam logic [2:0] B_CLR = 3'b100;

  logic clk = 1'b0;
  logic reset;

  stopwatch_run_ctrl_if #(.COUNT_W(CW)) bus ();

  stopwatch_run_ctrl #(.DEBOUNCE_CYCLES(DB), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    btns;
    logic [CW-1:0] sw;
    logic [1:0]    st;
    logic          rs;
    logic          la;
    logic [3:0]    ln;
    logic [CW-1:0] disp;
    int unsigned   clr;
    string         name;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sbq[$];
  int          passed = 0;
  int          total  = 0;
  int unsigned clr_seen = 0;
  int unsigned clr_base = 0;

  always @(negedge clk) if (bus.clear === 1'b1) clr_seen++;

  function automatic vec_t mk(input logic [2:0] b, input logic [CW-1:0] sw, input logic [1:0] st,
                              input logic rs, input logic la, input logic [3:0] ln,
                              input logic [CW-1:0] disp, input int unsigned clr, input string name);
    vec_t v;
    v.btns = b; v.sw = sw; v.st = st; v.rs = rs; v.la = la;
    v.ln = ln; v.disp = disp; v.clr = clr; v.name = name;
    return v;
  endfunction

  task automatic sb_check();
    vec_t e;
    int unsigned got_clr;
    e = sbq.pop_front();
    got_clr = clr_seen - clr_base;
    total++;
    if (bus.state === e.st && bus.run_stop === e.rs && bus.lap_active === e.la &&
        bus.lap_num === e.ln && bus.disp_count === e.disp && got_clr == e.clr)
      passed++;
    else
      $display("FAIL %s: got st=%0d rs=%0b la=%0b ln=%0d disp=%0d clr=%0d, want st=%0d rs=%0b la=%0b ln=%0d disp=%0d clr=%0d",
               e.name, bus.state, bus.run_stop, bus.lap_active, bus.lap_num, bus.disp_count, got_clr,
               e.st, e.rs, e.la, e.ln, e.disp, e.clr);
  endtask

  task automatic expect_now(input logic [1:0] st, input logic rs, input logic la, input logic [3:0] ln,
                            input logic [CW-1:0] disp, input int unsigned clr, input string name);
    sbq.push_back(mk(3'b000, bus.sw_count, st, rs, la, ln, disp, clr, name));
    sb_check();
  endtask

  task automatic drive_btns(input logic [2:0] m);
    bus.btn_run   = m[0];
    bus.btn_lap   = m[1];
    bus.btn_clear = m[2];
  endtask

  task automatic press(input logic [2:0] m);
    @(negedge clk);
    drive_btns(m);
    repeat (12) @(negedge clk);
    drive_btns(3'b000);
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clr_base = clr_seen;
  endtask

  task automatic check_lap_value_zero(input string name);
    total++;
    if (dut.lap_value_q === '0) passed++;
    else $display("FAIL %s: got lap_value=%0d, want 0", name, dut.lap_value_q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_btns(3'b000);
    bus.sw_count = '0;

    tbl.push_back(mk(B_RUN,         CW'(100),  ST_RUN,   1, 0, 0, CW'(100),  0, "run_from_idle"));
    tbl.push_back(mk(B_CLR,         CW'(200),  ST_RUN,   1, 0, 0, CW'(200),  0, "clr_in_run_ignored"));
    tbl.push_back(mk(B_LAP,         CW'(1234), ST_LAP,   1, 1, 1, CW'(1234), 0, "lap_capture"));
    tbl.push_back(mk(3'b000,        CW'(1300), ST_LAP,   1, 1, 1, CW'(1234), 0, "lap_frozen"));
    tbl.push_back(mk(B_LAP,         CW'(1400), ST_RUN,   1, 0, 1, CW'(1400), 0, "lap_release"));
    tbl.push_back(mk(B_LAP,         CW'(1500), ST_LAP,   1, 1, 2, CW'(1500), 0, "lap_second"));
    tbl.push_back(mk(B_RUN,         CW'(1600), ST_PAUSE, 0, 0, 2, CW'(1600), 0, "run_in_lap_pauses"));
    tbl.push_back(mk(B_LAP,         CW'(1700), ST_PAUSE, 0, 0, 2, CW'(1700), 0, "lap_in_pause_ignored"));
    tbl.push_back(mk(B_CLR,         CW'(1800), ST_IDLE,  0, 0, 0, CW'(1800), 1, "clr_in_pause"));
    tbl.push_back(mk(B_CLR,         CW'(1900), ST_IDLE,  0, 0, 0, CW'(1900), 1, "clr_in_idle"));
    tbl.push_back(mk(B_LAP,         CW'(2000), ST_IDLE,  0, 0, 0, CW'(2000), 0, "lap_in_idle_ignored"));
    tbl.push_back(mk(B_RUN,         CW'(2100), ST_RUN,   1, 0, 0, CW'(2100), 0, "run_again"));
    tbl.push_back(mk(B_RUN | B_LAP, CW'(2200), ST_PAUSE, 0, 0, 0, CW'(2200), 0, "run_lap_same_cycle"));
    tbl.push_back(mk(B_RUN | B_CLR, CW'(2300), ST_IDLE,  0, 0, 0, CW'(2300), 1, "clr_beats_run"));
    tbl.push_back(mk(B_RUN,         CW'(2400), ST_RUN,   1, 0, 0, CW'(2400), 0, "run_third"));
    tbl.push_back(mk(B_LAP, CW'(SW_MAX_COUNT), ST_LAP,   1, 1, 1, CW'(SW_MAX_COUNT), 0, "lap_max_count"));
    tbl.push_back(mk(B_RUN,         CW'(100),  ST_PAUSE, 0, 0, 1, CW'(100),  0, "pause_from_lap"));
    tbl.push_back(mk(B_CLR,         CW'(0),    ST_IDLE,  0, 0, 0, CW'(0),    1, "clr_zeroes_laps"));

    repeat (3) @(negedge clk);
    clr_base = clr_seen;
    expect_now(ST_IDLE, 0, 0, 0, CW'(0), 0, "reset_state");
    reset = 1'b0;

    // Exact press-to-RUN latency, with the button held well beyond it.
    @(negedge clk);
    bus.btn_run = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    expect_now(ST_IDLE, 0, 0, 0, CW'(0), 0, "before_latency");
    @(negedge clk);
    expect_now(ST_RUN, 1, 0, 0, CW'(0), 0, "at_latency");
    repeat (10) @(negedge clk);
    expect_now(ST_RUN, 1, 0, 0, CW'(0), 0, "held_single_pulse");
    drive_btns(3'b000);
    repeat (12) @(negedge clk);
    do_reset();

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    foreach (tbl[i]) begin end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.btn_run = (i % 2 == 0);
    end
    @(negedge clk);
    bus.btn_run = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    expect_now(ST_IDLE, 0, 0, 0, CW'(0), 0, "bounce_not_yet");
    @(negedge clk);
    expect_now(ST_RUN, 1, 0, 0, CW'(0), 0, "bounce_accepted");
    repeat (10) @(negedge clk);
    expect_now(ST_RUN, 1, 0, 0, CW'(0), 0, "bounce_one_pulse");
    drive_btns(3'b000);
    repeat (12) @(negedge clk);
    do_reset();
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      clr_base = clr_seen;
      bus.sw_count = tbl[i].sw;
      sbq.push_back(tbl[i]);
      press(tbl[i].btns);
      sb_check();
    end
    check_lap_value_zero("lap_value_after_clear");

    press(B_RUN);
    for (int i = 1; i <= 17; i++) begin
      clr_base = clr_seen;
      bus.sw_count = CW'(i * 10);
      sbq.push_back(mk(B_LAP, CW'(i * 10), ST_LAP, 1, 1,
                       (i > 15) ? LAP_NUM_MAX : 4'(i), CW'(i * 10), 0, "lap_saturate"));
      press(B_LAP);
      sb_check();
      if (i < 17) press(B_LAP);
    end

    clr_base = clr_seen;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 expect_now(ST_IDLE, 0, 0, 0, CW'(170), 0, "reset_in_lap_immediate");
    repeat (3) @(negedge clk);
    expect_now(ST_IDLE, 0, 0, 0, CW'(170), 0, "reset_in_lap_held");
    check_lap_value_zero("lap_value_after_reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_now(ST_IDLE, 0, 0, 0, CW'(170), 0, "after_reset_no_clear");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
